iceclock_supervisor: RTL and testbench
======================================

Name: iceclock_supervisor

Overview:
- Parametrised successor to the fixed-speed clock wrapper.
- Sits directly behind the PLL (or the raw 12 MHz pin) and supervises its lock signal.
- Generates a lock-qualified, stabilised system reset, plus CHANNELS independent clock-enable tick streams with runtime-programmable divisors.
- Downstream logic runs on `clock` and is gated by these ticks instead of instantiating extra PLLs.

Parameters:
- SPEED, 48, frequency of `clock` in MHz; used only to scale the hold time.
- HOLD_US, 100, lock-stable time before reset release, in microseconds. Hold count H = SPEED*HOLD_US; H must be >= 1.
- CHANNELS, 4, number of tick channels; must be >= 1.
- DIV_WIDTH, 16, width of each channel divisor.

Ports:
- clock  in  1  supervised clock (PLL output); sole clock of the block.
- reset_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL lock flag, asynchronous to `clock`.
- divisor  in  CHANNELS*DIV_WIDTH  channel k divisor at bits [k*DIV_WIDTH +: DIV_WIDTH].
- enable  in  CHANNELS  per-channel tick enable.
- tick  out  CHANNELS  one-cycle clock-enable pulses.
- sys_reset_n  out  1  downstream reset; asserts with lock loss, deasserts synchronously.
- state  out  2  FSM state: 0 WAIT_LOCK, 1 STABILIZE, 2 RUN, 3 LOST.

Behaviour:
Reset values (reset_n low):
- All flops clear asynchronously: state=0, sys_reset_n=0, tick=0, hold counter=0, channel counters=0, synchroniser=0.

Lock synchroniser:
- `pll_locked` passes through 2 flops to give lk.
- All FSM decisions use lk only.

FSM (all outputs registered):
- WAIT_LOCK: hold counter=0. lk=1 -> STABILIZE.
- STABILIZE: hold counter increments each cycle while lk=1.
  - lk=0 -> WAIT_LOCK; counter restarts from 0 on the next attempt.
  - Counter = H-1 with lk=1 -> RUN. Exactly H consecutive STABILIZE cycles precede RUN.
- RUN: lk=0 -> LOST.
- LOST: lasts exactly one cycle, then -> WAIT_LOCK unconditionally.
- sys_reset_n is a flop: 1 in exactly the cycles where state=RUN.
  - It rises on the same edge that enters RUN.
  - It falls on the same edge that enters LOST.
- Hold counter width: $clog2(H+1).

Tick channels (independent, identical):
- Per-channel counter cnt (DIV_WIDTH bits) and captured divisor dq.
- Effective divisor D = max(dq, 1); a divisor of 0 behaves as 1.
- Counting runs only when state=RUN and enable[k]=1.
- Each counting cycle:
  - If cnt==0, dq <= divisor[k] and the period is evaluated with the newly sampled value.
  - If cnt >= D-1: cnt <= 0 and tick[k] <= 1.
  - Otherwise cnt <= cnt+1 and tick[k] <= 0.
- Result: tick[k] is high 1 cycle in every D. The first tick comes on the D-th edge after enable is first sampled high in RUN.
- Divisor changes take effect only at the next period boundary (cnt==0).
- enable[k]=0, or state != RUN: cnt <= 0, tick[k] <= 0. Re-enabling starts a fresh period.
- Boundary cases:
  - D = 2^DIV_WIDTH-1 is legal; cnt never overflows.
  - Lock loss mid-period discards the partial period.

Optional Feature:
- Macro: ICECLOCK_SUPERVISOR_LOSTCNT_EN.
- Defined:
  - Adds output port `lost_count` (8 bits, reset 0).
  - Increments by 1 on every RUN->LOST transition.
  - Saturates at 255; cleared only by reset_n.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- SPEED=1, HOLD_US=10, pll_locked=1 from release of reset_n:
  - state 0->1 after 2 synchroniser cycles.
  - Exactly 10 cycles in state 1, then state=2 and sys_reset_n=1 on the same edge.
- Same parameters, pll_locked low for 1 cycle at STABILIZE cycle 5:
  - Returns to WAIT_LOCK.
  - After re-lock, a full 10 STABILIZE cycles elapse before RUN.
- RUN, CHANNELS=3, divisors {1,4,0}, all enables high:
  - ch0 and ch2 tick every cycle.
  - ch1 ticks on edges 4, 8, 12 after entering RUN.
- ch1 divisor changed 4->6 at cnt=1:
  - Current period still ends after 4 cycles.
  - Subsequent ticks are spaced 6 apart.
  - enable low then high restarts the period (first tick 6 cycles later).
- pll_locked dropped in RUN:
  - Within 3 edges: state=3, sys_reset_n=0, all ticks 0.
  - Next cycle state=0.
  - With macro defined, lost_count goes 0->1; 300 such losses give 255.
- reset_n pulsed low mid-RUN, asynchronous to clock:
  - All outputs go to reset values immediately, without waiting for an edge.
  - The FSM restarts the WAIT_LOCK sequence.

Source files
------------

// File: rtl/iceclock_supervisor.sv
// iceclock_supervisor
//
// Supervises the PLL lock flag, produces a lock-qualified and stabilised
// system reset, and generates CHANNELS independent clock-enable tick streams
// with runtime-programmable divisors. Everything runs on `clock`.
//
// Parameters:
//   SPEED     clock frequency in MHz (only scales the hold time)
//   HOLD_US   lock-stable time before reset release, in microseconds
//   CHANNELS  number of tick channels (>= 1)
//   DIV_WIDTH width of each channel divisor
//
// Ports:
//   clock        in   supervised clock, sole clock of the block
//   reset_n      in   asynchronous active-low reset
//   pll_locked   in   PLL lock flag, asynchronous to clock
//   divisor      in   channel k divisor at [k*DIV_WIDTH +: DIV_WIDTH]
//   enable       in   per-channel tick enable
//   tick         out  one-cycle clock-enable pulses, one per channel
//   sys_reset_n  out  downstream reset, high only while in RUN
//   state        out  0 WAIT_LOCK, 1 STABILIZE, 2 RUN, 3 LOST
//   lost_count   out  (only with ICECLOCK_SUPERVISOR_LOSTCNT_EN defined)
//                     saturating count of RUN->LOST transitions
//
// Optional feature macro: ICECLOCK_SUPERVISOR_LOSTCNT_EN

module iceclock_supervisor #(
    parameter int SPEED     = 48,
    parameter int HOLD_US   = 100,
    parameter int CHANNELS  = 4,
    parameter int DIV_WIDTH = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          pll_locked,
    input  logic [CHANNELS*DIV_WIDTH-1:0] divisor,
    input  logic [CHANNELS-1:0]           enable,
    output logic [CHANNELS-1:0]           tick,
    output logic                          sys_reset_n,
    output logic [1:0]                    state
`ifdef ICECLOCK_SUPERVISOR_LOSTCNT_EN
    ,
    output logic [7:0]                    lost_count
`endif
);

    localparam int H      = SPEED * HOLD_US;
    localparam int HOLD_W = $clog2(H + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(H - 1);

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_STABILIZE = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;
    localparam logic [1:0] ST_LOST      = 2'd3;

    logic              lk_meta_q;
    logic              lk_q;
    logic [1:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              srst_n_q;

    logic [DIV_WIDTH-1:0] cnt_q  [CHANNELS];
    logic [DIV_WIDTH-1:0] cnt_d  [CHANNELS];
    logic [DIV_WIDTH-1:0] dq_q   [CHANNELS];
    logic [DIV_WIDTH-1:0] dq_d   [CHANNELS];
    logic [DIV_WIDTH-1:0] last_v [CHANNELS];
    logic [CHANNELS-1:0]  tick_q, tick_d;

    // Counting needs RUN both now and on the next edge, so a lock loss
    // clears the channels on the same edge that enters LOST.
    logic run_keep;
    assign run_keep = (state_q == ST_RUN) && lk_q;

    // Two-flop synchroniser for the asynchronous lock flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lk_meta_q <= 1'b0;
            lk_q      <= 1'b0;
        end else begin
            lk_meta_q <= pll_locked;
            lk_q      <= lk_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lk_q) begin
                    state_d = ST_STABILIZE;
                end
            end
            ST_STABILIZE: begin
                if (!lk_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lk_q) begin
                    state_d = ST_LOST;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_WAIT_LOCK;
            hold_q   <= '0;
            srst_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            srst_n_q <= (state_d == ST_RUN);
        end
    end

    // Per-channel divider. The divisor is captured only at a period boundary
    // (cnt==0) and used immediately, so a change never truncates a period.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            cnt_d[k]  = '0;
            dq_d[k]   = dq_q[k];
            last_v[k] = '0;
            tick_d[k] = 1'b0;
            if (run_keep && enable[k]) begin
                if (cnt_q[k] == '0) begin
                    dq_d[k] = divisor[k*DIV_WIDTH +: DIV_WIDTH];
                end
                // D-1 with a zero divisor treated as one.
                last_v[k] = (dq_d[k] == '0) ? '0 : dq_d[k] - 1'b1;
                if (cnt_q[k] >= last_v[k]) begin
                    cnt_d[k]  = '0;
                    tick_d[k] = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_q <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                cnt_q[k] <= '0;
                dq_q[k]  <= '0;
            end
        end else begin
            tick_q <= tick_d;
            for (int k = 0; k < CHANNELS; k++) begin
                cnt_q[k] <= cnt_d[k];
                dq_q[k]  <= dq_d[k];
            end
        end
    end

`ifdef ICECLOCK_SUPERVISOR_LOSTCNT_EN
    logic [7:0] lost_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lost_q <= '0;
        end else if ((state_q == ST_RUN) && (state_d == ST_LOST) && (lost_q != 8'hFF)) begin
            lost_q <= lost_q + 1'b1;
        end
    end

    assign lost_count = lost_q;
`endif

    assign state       = state_q;
    assign sys_reset_n = srst_n_q;
    assign tick        = tick_q;

endmodule

// File: tb/tb_iceclock_supervisor.sv
module tb_iceclock_supervisor;

    localparam int SPEED = 1;
    localparam int HOLD_US = 10;
    localparam int CH = 3;
    localparam int DW = 8;
    localparam int H = SPEED * HOLD_US;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic              pll_locked = 1'b0;
    logic [CH*DW-1:0]  divisor = '0;
    logic [CH-1:0]     enable = '0;
    logic [CH-1:0]     tick;
    logic              sys_reset_n;
    logic [1:0]        state;
`ifdef ICECLOCK_SUPERVISOR_LOSTCNT_EN
    logic [7:0]        lost_count;
`endif

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    iceclock_supervisor #(
        .SPEED(SPEED), .HOLD_US(HOLD_US), .CHANNELS(CH), .DIV_WIDTH(DW)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .pll_locked(pll_locked),
        .divisor(divisor),
        .enable(enable),
        .tick(tick),
        .sys_reset_n(sys_reset_n),
        .state(state)
`ifdef ICECLOCK_SUPERVISOR_LOSTCNT_EN
        ,
        .lost_count(lost_count)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: lock seen two edges late, a stabilisation run length,
    // and per-channel position within a period of latched length.
    int m_state = 0;
    int m_stab = 0;
    int m_s1 = 0;
    int m_s2 = 0;
    int m_lost = 0;
    int m_pos [CH];
    int m_per [CH];
    logic [CH-1:0] m_tick = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0; m_stab = 0; m_s1 = 0; m_s2 = 0; m_lost = 0; m_tick = '0;
            for (int k = 0; k < CH; k++) begin
                m_pos[k] = 0;
                m_per[k] = 1;
            end
        end else begin
            int lk;
            int dv;
            bit counting;
            lk = m_s2;
            counting = (m_state == 2) && (lk == 1);
            for (int k = 0; k < CH; k++) begin
                if (counting && enable[k]) begin
                    if (m_pos[k] == 0) begin
                        dv = int'(divisor[k*DW +: DW]);
                        m_per[k] = (dv == 0) ? 1 : dv;
                    end
                    m_pos[k]++;
                    if (m_pos[k] == m_per[k]) begin
                        m_tick[k] = 1'b1;
                        m_pos[k] = 0;
                    end else begin
                        m_tick[k] = 1'b0;
                    end
                end else begin
                    m_pos[k] = 0;
                    m_tick[k] = 1'b0;
                end
            end
            if (m_state == 2 && lk == 0 && m_lost < 255) m_lost++;
            case (m_state)
                0: if (lk == 1) begin m_state = 1; m_stab = 0; end
                1: begin
                    if (lk == 0) m_state = 0;
                    else begin
                        m_stab++;
                        if (m_stab == H) m_state = 2;
                    end
                end
                2: if (lk == 0) m_state = 3;
                default: m_state = 0;
            endcase
            m_s2 = m_s1;
            m_s1 = int'(pll_locked);
        end
    end

    always @(negedge clock) begin
        chk("state", int'(state), m_state);
        chk("sys_reset_n", int'(sys_reset_n), int'(m_state == 2));
        chk("tick", int'(tick), int'(m_tick));
`ifdef ICECLOCK_SUPERVISOR_LOSTCNT_EN
        chk("lost_count", int'(lost_count), m_lost);
`endif
    end

    task automatic wait_state(input int s, input int budget);
        int n;
        n = 0;
        while (int'(state) != s && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (int'(state) != s) chk("wait_state_timeout", int'(state), s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        pll_locked = 1'b1;
        divisor = {8'd0, 8'd4, 8'd1};
        #1 reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("lit_reset_state", int'(state), 0);
        chk("lit_reset_srst", int'(sys_reset_n), 0);
        chk("lit_reset_tick", int'(tick), 0);

        // Release with lock already high.
        reset_n = 1'b1;
        enable = 3'b111;
        repeat (2) @(negedge clock);
        chk("lit_sync_wait", int'(state), 0);
        @(negedge clock);
        chk("lit_stab_entry", int'(state), 1);
        repeat (9) @(negedge clock);
        chk("lit_stab_last", int'(state), 1);
        @(negedge clock);
        chk("lit_run_entry", int'(state), 2);
        chk("lit_run_srst", int'(sys_reset_n), 1);

        // Divisors {1,4,0}: ch1 ticks every 4th edge, ch0/ch2 every edge.
        for (int r = 1; r <= 12; r++) begin
            @(negedge clock);
            chk("lit_ch1_div4", int'(tick[1]), int'(r % 4 == 0));
            chk("lit_ch0_div1", int'(tick[0]), 1);
            chk("lit_ch2_div0", int'(tick[2]), 1);
        end

        // Change ch1 to 6 while cnt=1: current period still ends at 16.
        for (int r = 13; r <= 28; r++) begin
            @(negedge clock);
            chk("lit_ch1_change", int'(tick[1]), int'(r == 16 || r == 22 || r == 28));
            if (r == 13) divisor[DW +: DW] = 8'd6;
        end

        // Drop and restore enable: fresh period of 6.
        enable[1] = 1'b0;
        @(negedge clock);
        chk("lit_ch1_disabled", int'(tick[1]), 0);
        enable[1] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            chk("lit_ch1_restart", int'(tick[1]), int'(i == 6));
        end

        // Largest divisor for the width.
        divisor[2*DW +: DW] = 8'd255;
        for (int p = 0; p < 2; p++) begin
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (tick[2] == 1'b0 && n < 300);
            chk("lit_ch2_div255", n, 255);
        end

        // Lock loss in RUN.
        pll_locked = 1'b0;
        repeat (3) @(negedge clock);
        chk("lit_lost_state", int'(state), 3);
        chk("lit_lost_srst", int'(sys_reset_n), 0);
        chk("lit_lost_tick", int'(tick), 0);
        @(negedge clock);
        chk("lit_after_lost", int'(state), 0);
`ifdef ICECLOCK_SUPERVISOR_LOSTCNT_EN
        chk("lit_lost_count1", int'(lost_count), 1);
`endif
        pll_locked = 1'b1;
        wait_state(2, 40);

        // Repeated single-cycle lock drops.
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            @(negedge clock);
            pll_locked = 1'b1;
            wait_state(3, 10);
            wait_state(2, 40);
        end
`ifdef ICECLOCK_SUPERVISOR_LOSTCNT_EN
        chk("lit_lost_count_sat", int'(lost_count), 255);
`endif

        // Asynchronous reset between edges.
        #2 reset_n = 1'b0;
        #1;
        chk("lit_async_state", int'(state), 0);
        chk("lit_async_srst", int'(sys_reset_n), 0);
        chk("lit_async_tick", int'(tick), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Restart, with a one-cycle lock glitch in STABILIZE cycle 5.
        repeat (3) @(negedge clock);
        chk("lit_restart_stab", int'(state), 1);
        repeat (2) @(negedge clock);
        pll_locked = 1'b0;
        @(negedge clock);
        pll_locked = 1'b1;
        @(negedge clock);
        chk("lit_glitch_stab5", int'(state), 1);
        @(negedge clock);
        chk("lit_glitch_wait", int'(state), 0);
        @(negedge clock);
        chk("lit_relock_stab", int'(state), 1);
        repeat (9) @(negedge clock);
        chk("lit_relock_stab10", int'(state), 1);
        @(negedge clock);
        chk("lit_relock_run", int'(state), 2);
        chk("lit_relock_srst", int'(sys_reset_n), 1);

        repeat (2) @(negedge clock);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
